// File: rtl/dl_tdc_histogrammer_if.sv
// Control, readout and observation bus of the delay-line histogrammer.
// The master side drives the run controls and read address; the slave is the histogrammer.
interface dl_tdc_histogrammer_if #(
    parameter int LENGTH = 16,
    parameter int CNT_W  = 16
);
    localparam int CODE_W = $clog2(LENGTH + 1);

    logic              mode_i;
    logic              hit_i;
    logic              start_i;
    logic [CODE_W-1:0] rd_addr_i;
    logic              busy_o;
    logic              done_o;
    logic [LENGTH-1:0] dout_r;
    logic [CODE_W-1:0] code_o;
    logic              code_valid_o;
    logic [CNT_W-1:0]  rd_data_o;

    modport master (
        output mode_i, hit_i, start_i, rd_addr_i,
        input  busy_o, done_o, dout_r, code_o, code_valid_o, rd_data_o
    );

    modport slave (
        input  mode_i, hit_i, start_i, rd_addr_i,
        output busy_o, done_o, dout_r, code_o, code_valid_o, rd_data_o
    );
endinterface

// File: rtl/dl_tdc_histogrammer.sv
// Carry-chain delay-line sampler with first-transition encoder and code-density histogram.
// Code appears 3 clk after the chain input, readout has 1 clk latency; no backpressure, start ignored while busy.
module dl_tdc_histogrammer #(
    parameter int LENGTH    = 16,
    parameter int CNT_W     = 16,
    parameter int SAMPLES_W = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    dl_tdc_histogrammer_if.slave   bus
);
    localparam int                CODE_W    = $clog2(LENGTH + 1);
    localparam int                NBINS     = LENGTH + 1;
    localparam logic [CODE_W-1:0] LAST_ADDR = CODE_W'(LENGTH);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

    // Chain nets are kept so the adder maps onto the physical carry chain under test.
    (* keep = "true" *) logic [LENGTH-1:0] chain_ones;
    (* keep = "true" *) logic [LENGTH-1:0] chain_sum;
    logic                                  din;

    assign chain_ones = '1;
    assign din        = bus.mode_i ? bus.hit_i : clk;
    assign chain_sum  = chain_ones + LENGTH'(din);

    logic [LENGTH-1:0]    sync_q;
    logic [1:0]           fill_q;
    logic [CODE_W-1:0]    code_d;

    state_t               state_q, state_d;
    logic [CODE_W-1:0]    clr_addr_q;
    logic [SAMPLES_W-1:0] smp_q;
    logic [CNT_W-1:0]     bins_q [NBINS];

    // Position of the lowest set tap; bubbles above it do not matter.
    always_comb begin
        code_d = LAST_ADDR;
        for (int i = LENGTH - 1; i >= 0; i--) begin
            if (sync_q[i]) code_d = CODE_W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dout_r       <= '0;
            sync_q           <= '0;
            bus.code_o       <= '0;
            bus.code_valid_o <= 1'b0;
            fill_q           <= 2'd0;
        end else begin
            bus.dout_r <= chain_sum;
            sync_q     <= bus.dout_r;
            bus.code_o <= code_d;
            if (fill_q != 2'd3) fill_q <= fill_q + 2'd1;
            if (fill_q == 2'd2) bus.code_valid_o <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start_i) state_d = S_CLEAR;
            S_CLEAR: if (clr_addr_q == LAST_ADDR) state_d = S_RUN;
            S_RUN:   if (bus.code_valid_o && (smp_q == '1)) state_d = S_DONE;
            S_DONE:  if (bus.start_i) state_d = S_CLEAR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bus.busy_o <= 1'b0;
            bus.done_o <= 1'b0;
            clr_addr_q <= '0;
            smp_q      <= '0;
        end else begin
            state_q    <= state_d;
            bus.busy_o <= (state_d == S_CLEAR) || (state_d == S_RUN);
            bus.done_o <= (state_d == S_DONE);
            clr_addr_q <= (state_q == S_CLEAR) ? clr_addr_q + 1'b1 : '0;
            if (state_q != S_RUN)       smp_q <= '0;
            else if (bus.code_valid_o)  smp_q <= smp_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NBINS; b++) bins_q[b] <= '0;
        end else if (state_q == S_CLEAR) begin
            bins_q[clr_addr_q] <= '0;
        end else if ((state_q == S_RUN) && bus.code_valid_o && (bins_q[bus.code_o] != '1)) begin
            bins_q[bus.code_o] <= bins_q[bus.code_o] + 1'b1;
        end
    end

    // Bins are only visible while no run is modifying them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rd_data_o <= '0;
        end else if (((state_q == S_IDLE) || (state_q == S_DONE)) && (bus.rd_addr_i <= LAST_ADDR)) begin
            bus.rd_data_o <= bins_q[bus.rd_addr_i];
        end else begin
            bus.rd_data_o <= '0;
        end
    end
endmodule

// File: tb/tb_dl_tdc_histogrammer.sv
// Self-checking bench: two histogrammers (wide and 3-bit bins) driven in lockstep by hit_i.
module tb_dl_tdc_histogrammer;
    localparam int L  = 16;
    localparam int SW = 4;
    localparam int NS = 1 << SW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dl_tdc_histogrammer_if #(.LENGTH(L), .CNT_W(16)) a_if ();
    dl_tdc_histogrammer_if #(.LENGTH(L), .CNT_W(3))  b_if ();

    dl_tdc_histogrammer #(.LENGTH(L), .CNT_W(16), .SAMPLES_W(SW)) dut_a (
        .clk (clk), .rst (rst), .bus (a_if.slave)
    );
    dl_tdc_histogrammer #(.LENGTH(L), .CNT_W(3), .SAMPLES_W(SW)) dut_b (
        .clk (clk), .rst (rst), .bus (b_if.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    int ecount = 0;
    bit hist [0:8191];

    // Edge counter and log of the hit level each edge sampled.
    always @(posedge clk) begin
        ecount = ecount + 1;
        hist[ecount % 8192] = a_if.hit_i;
    end

    task automatic drive(input bit hit, input bit start, input logic [4:0] addr);
        a_if.mode_i = 1'b1; a_if.hit_i = hit; a_if.start_i = start; a_if.rd_addr_i = addr;
        b_if.mode_i = 1'b1; b_if.hit_i = hit; b_if.start_i = start; b_if.rd_addr_i = addr;
    endtask

    task automatic test_reset;
        drive(1'b0, 1'b0, 5'd0);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({a_if.busy_o, a_if.done_o, a_if.code_valid_o, a_if.dout_r, a_if.code_o, a_if.rd_data_o} !== '0) begin
            n_err++; $display("FAIL reset_state_a got %h want 0",
                {a_if.busy_o, a_if.done_o, a_if.code_valid_o, a_if.dout_r, a_if.code_o, a_if.rd_data_o});
        end
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (a_if.code_valid_o !== (k == 3)) begin
                n_err++; $display("FAIL valid_rise edge=%0d got %b want %b", k, a_if.code_valid_o, (k == 3));
            end
        end
        repeat (2) @(negedge clk);
        // Asynchronous assertion between edges must clear outputs immediately.
        @(posedge clk); #2; rst = 1'b1; #1;
        n_cmp++;
        if ({a_if.busy_o, a_if.done_o, a_if.code_valid_o, a_if.dout_r, a_if.code_o, a_if.rd_data_o} !== '0) begin
            n_err++; $display("FAIL async_reset_a got %h want 0",
                {a_if.busy_o, a_if.done_o, a_if.code_valid_o, a_if.dout_r, a_if.code_o, a_if.rd_data_o});
        end
        n_cmp++;
        if ({b_if.code_valid_o, b_if.dout_r, b_if.code_o} !== '0) begin
            n_err++; $display("FAIL async_reset_b got %h want 0", {b_if.code_valid_o, b_if.dout_r, b_if.code_o});
        end
        @(negedge clk); rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (b_if.code_valid_o !== (k == 3)) begin
                n_err++; $display("FAIL valid_rise2 edge=%0d got %b want %b", k, b_if.code_valid_o, (k == 3));
            end
        end
    endtask

    task automatic test_pipeline;
        drive(1'b0, 1'b0, 5'd0);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (a_if.dout_r !== 16'hFFFF || a_if.code_o !== 5'd0) begin
            n_err++; $display("FAIL hit0_hold got dout=%h code=%0d want dout=ffff code=0", a_if.dout_r, a_if.code_o);
        end
        drive(1'b1, 1'b0, 5'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (a_if.dout_r !== 16'h0000) begin
                n_err++; $display("FAIL hit1_dout edge=%0d got %h want 0000", k, a_if.dout_r);
            end
            n_cmp++;
            if (a_if.code_o !== ((k >= 3) ? 5'd16 : 5'd0)) begin
                n_err++; $display("FAIL hit1_latency edge=%0d got %0d want %0d", k, a_if.code_o, (k >= 3) ? 16 : 0);
            end
        end
        drive(1'b0, 1'b0, 5'd0);
        repeat (3) @(negedge clk);
    endtask

    // pattern 0: hit held high, 1: toggle every cycle, 2/3: random.
    task automatic test_run(input int pattern, input bit poke);
        int s, e, idx, ad;
        int ea [0:L];
        int eb [0:L];
        bit h;
        h = 1'b0;
        @(negedge clk);
        h = (pattern == 0) ? 1'b1 : (pattern == 1) ? ~h : 1'($urandom_range(0, 1));
        drive(h, 1'b1, 5'd16);
        @(negedge clk);
        s = ecount;
        for (int i = 0; i <= L + NS + 2; i++) begin
            e = ecount;
            n_cmp++;
            if (a_if.busy_o !== (e >= s && e <= s + L + NS) || b_if.busy_o !== a_if.busy_o) begin
                n_err++; $display("FAIL busy p=%0d rel=%0d got %b/%b want %b", pattern, e - s,
                    a_if.busy_o, b_if.busy_o, (e >= s && e <= s + L + NS));
            end
            n_cmp++;
            if (a_if.done_o !== (e >= s + L + NS + 1) || b_if.done_o !== a_if.done_o) begin
                n_err++; $display("FAIL done p=%0d rel=%0d got %b/%b want %b", pattern, e - s,
                    a_if.done_o, b_if.done_o, (e >= s + L + NS + 1));
            end
            n_cmp++;
            if (a_if.dout_r !== (hist[e % 8192] ? 16'h0000 : 16'hFFFF)) begin
                n_err++; $display("FAIL dout p=%0d rel=%0d got %h", pattern, e - s, a_if.dout_r);
            end
            n_cmp++;
            if (b_if.code_o !== (hist[(e - 2) % 8192] ? 5'd16 : 5'd0)) begin
                n_err++; $display("FAIL code p=%0d rel=%0d got %0d want %0d", pattern, e - s,
                    b_if.code_o, hist[(e - 2) % 8192] ? 16 : 0);
            end
            if (e >= s + 1 && e <= s + L + NS + 1) begin
                n_cmp++;
                if (a_if.rd_data_o !== 16'd0 || b_if.rd_data_o !== 3'd0) begin
                    n_err++; $display("FAIL rd_busy rel=%0d got %0d/%0d want 0", e - s, a_if.rd_data_o, b_if.rd_data_o);
                end
            end
            h = (pattern == 0) ? 1'b1 : (pattern == 1) ? ~h : 1'($urandom_range(0, 1));
            drive(h, poke && (e == s + L + 5), 5'd16);
            @(negedge clk);
        end
        // Reference: exactly NS samples, each counting the hit seen 3 edges before its RUN edge.
        for (int b = 0; b <= L; b++) begin ea[b] = 0; eb[b] = 0; end
        for (int k = 0; k < NS; k++) begin
            idx = hist[(s + L + 2 + k - 3) % 8192] ? L : 0;
            if (ea[idx] < 65535) ea[idx]++;
            if (eb[idx] < 7)     eb[idx]++;
        end
        for (int j = 0; j <= L + 1; j++) begin
            ad = (j == L + 1) ? 31 : j;
            drive(1'b0, 1'b0, 5'(ad));
            @(negedge clk);
            n_cmp++;
            if (a_if.rd_data_o !== 16'((ad <= L) ? ea[ad] : 0)) begin
                n_err++; $display("FAIL bin_a p=%0d addr=%0d got %0d want %0d", pattern, ad,
                    a_if.rd_data_o, (ad <= L) ? ea[ad] : 0);
            end
            n_cmp++;
            if (b_if.rd_data_o !== 3'((ad <= L) ? eb[ad] : 0)) begin
                n_err++; $display("FAIL bin_b p=%0d addr=%0d got %0d want %0d", pattern, ad,
                    b_if.rd_data_o, (ad <= L) ? eb[ad] : 0);
            end
        end
    endtask

    task automatic test_reset_mid_run;
        @(negedge clk);
        drive(1'b1, 1'b1, 5'd16);
        @(negedge clk);
        for (int i = 0; i < L + 8; i++) begin
            drive(1'($urandom_range(0, 1)), 1'b0, 5'd16);
            @(negedge clk);
        end
        @(posedge clk); #2; rst = 1'b1; #1;
        n_cmp++;
        if (a_if.busy_o !== 1'b0 || b_if.busy_o !== 1'b0 || a_if.done_o !== 1'b0) begin
            n_err++; $display("FAIL midrun_reset got busy=%b/%b done=%b want 0", a_if.busy_o, b_if.busy_o, a_if.done_o);
        end
        @(negedge clk); rst = 1'b0;
        drive(1'b0, 1'b0, 5'd0);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (a_if.busy_o !== 1'b0 || a_if.done_o !== 1'b0) begin
            n_err++; $display("FAIL idle_after_reset got busy=%b done=%b want 0", a_if.busy_o, a_if.done_o);
        end
        for (int j = 0; j <= 1; j++) begin
            drive(1'b0, 1'b0, (j == 0) ? 5'd0 : 5'd16);
            @(negedge clk);
            n_cmp++;
            if (a_if.rd_data_o !== 16'd0 || b_if.rd_data_o !== 3'd0) begin
                n_err++; $display("FAIL bins_cleared addr=%0d got %0d/%0d want 0", j * 16, a_if.rd_data_o, b_if.rd_data_o);
            end
        end
        test_run(2, 1'b0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 5'd0);
        test_reset;
        test_pipeline;
        test_run(0, 1'b0);
        test_run(1, 1'b1);
        test_run(2, 1'b0);
        test_reset_mid_run;
        test_run(3, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dl_tdc_histogrammer.md
Name: dl_tdc_histogrammer

Overview:
Parametrised carry-chain delay-line tester with on-chip code-density histogramming. A LENGTH-tap adder carry chain is driven by either the system clock (self-test) or an external hit line. Sampled taps are encoded to a first-transition code and accumulated into per-code bins over a programmable sample run. Bins are read back through a simple registered read port; the block is used for delay-line linearity characterisation on FPGA.

Parameters:
LENGTH, 16, number of carry-chain taps (>=4)
CNT_W, 16, bin counter width; bins saturate at 2^CNT_W-1
SAMPLES_W, 12, run length is 2^SAMPLES_W samples
CODE_W, $clog2(LENGTH+1), code and bin address width (derived, not overridable)

Ports:
clk  input  1  system clock; also the self-test chain stimulus
rst  input  1  asynchronous reset, active-high
mode_i  input  1  0: chain input = clk (self-test); 1: chain input = hit_i
hit_i  input  1  external hit, used when mode_i=1
start_i  input  1  single-cycle start-of-run request
rd_addr_i  input  CODE_W  bin read address
busy_o  output  1  high in CLEAR and RUN
done_o  output  1  high in DONE
dout_r  output  LENGTH  raw sampled chain taps
code_o  output  CODE_W  encoded code
code_valid_o  output  1  code_o valid
rd_data_o  output  CNT_W  bin contents, 1-cycle latency

Behaviour:
- Chain: sum = {LENGTH{1'b1}} + din, din = mode_i ? hit_i : clk; constant and sum nets carry synthesis keep so the carry chain is not optimised away. din=0 -> all ones; din=1 -> all zeros.
- Reset (rst high, async): dout_r=0, sync stage=0, code_o=0, code_valid_o=0, busy_o=0, done_o=0, rd_data_o=0, all bins=0, sample counter=0, FSM=IDLE.
- Pipeline: cycle 1 dout_r <= sum; cycle 2 sync register <= dout_r; cycle 3 code_o <= number of trailing zeros of sync register (position of first 1 from LSB), range 0..LENGTH; all zeros -> LENGTH. Bubbles above the first 1 are ignored.
- code_valid_o: low for the first 3 clk edges after reset release, then high permanently until next reset. A 2-bit fill counter provides this.
- FSM states: IDLE, CLEAR, RUN, DONE.
  IDLE: start_i -> CLEAR.
  CLEAR: one bin zeroed per cycle, addresses 0..LENGTH (LENGTH+1 cycles); then RUN with sample counter=0.
  RUN: each cycle with code_valid_o, bin[code_o] <= bin[code_o]+1, saturating at 2^CNT_W-1; sample counter increments; after the 2^SAMPLES_W-th sample -> DONE. Exactly 2^SAMPLES_W samples are accumulated.
  DONE: bins held; start_i -> CLEAR (new run). There is no path from DONE back to IDLE except reset.
- start_i in CLEAR or RUN: ignored, with no restart and no queueing.
- busy_o = (CLEAR|RUN), done_o = DONE; both registered state decodes.
- Readout: in IDLE/DONE, rd_data_o <= bin[rd_addr_i] on each clk. rd_addr_i > LENGTH returns 0. In CLEAR/RUN, rd_data_o <= 0.
- Reset mid-run: run is aborted and all state is cleared per the reset list; the next run requires a fresh start_i.
- Mode change mid-run: permitted. The following 3 codes may mix sources; the caller is responsible.
- mode_i=0 is a hardware-only measurement, because in zero-delay simulation the sample of clk at its own edge is a race. The bench uses mode_i=1 only.

Test Plan:
- Reset: assert rst mid-cycle with no clk edge -> all outputs 0 immediately; release rst -> code_valid_o rises on 3rd clk edge.
- mode_i=1, hit_i=0 held -> dout_r=16'hFFFF, code_o=0; hit_i=1 held -> dout_r=0, code_o=16, 3-cycle latency from hit_i change to code_o.
- SAMPLES_W=4, hit_i=1, start_i pulse -> busy_o 17 cycles of CLEAR + 16 RUN, then done_o=1. Read addr 16 -> 16, addr 0..15 -> 0, addr 31 -> 0, each one cycle after address.
- CNT_W=3, SAMPLES_W=4, hit_i toggled 0/1 per cycle -> bin0=7, bin16=7 (both saturated at 7, 8 samples each).
- start_i pulsed during RUN -> ignored, done_o at the original time. Second start_i in DONE -> bins cleared and new run counts fresh.
- rst asserted during RUN -> busy_o=0, bins=0, FSM in IDLE; start_i afterwards completes a normal run.
